// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module  : dmem_arb_pkg
//  Brief   : Shared FSM encodings and width helper for the dmem arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // Bits needed to index 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker; first valid at or after ptr.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_any_valid
);

    localparam int              IDX_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] c_NUM = IDX_W'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_mask;
    logic [2*NUM_REQ-1:0] w_masked;
    logic [IDX_W-1:0]     w_idx;

    // Masking the doubled vector below ptr makes the lowest surviving bit the
    // rotated winner without needing a barrel shifter.
    always_comb begin
        w_mask   = ~(((2*NUM_REQ)'(1) << i_ptr) - (2*NUM_REQ)'(1));
        w_masked = {i_req_valid, i_req_valid} & w_mask;
        w_idx    = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_idx = IDX_W'(i);
            end
        end
        o_any_valid = |i_req_valid;
        o_winner    = (w_idx >= c_NUM) ? PTR_W'(w_idx - c_NUM) : PTR_W'(w_idx);
        o_grant     = o_any_valid ? (NUM_REQ'(1) << o_winner) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_rr_arbiter.sv
// ============================================================================
//  Module  : dmem_rr_arbiter
//  Brief   : Round-robin arbiter sharing one synchronous dmem port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int               PTR_W  = clog2(NUM_REQ);
    localparam int               CNT_W  = clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] c_LAT  = CNT_W'(MEM_LATENCY);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_REQ - 1);

    logic [1:0]            r_state,   w_state_nxt;
    logic [PTR_W-1:0]      r_ptr,     w_ptr_nxt;
    logic [PTR_W-1:0]      r_owner,   w_owner_nxt;
    logic                  r_we,      w_we_nxt;
    logic [ADDR_W-1:0]     r_addr,    w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_nxt;
    logic [CNT_W-1:0]      r_lat_cnt, w_lat_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_winner;
    logic                  w_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_winner    (w_winner),
        .o_any_valid (w_any)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_lat_cnt_nxt = r_lat_cnt;
        w_rdata_nxt   = r_rdata;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_winner;
                    w_we_nxt    = req_we[w_winner];
                    w_addr_nxt  = req_addr[w_winner*ADDR_W +: ADDR_W];
                    w_wdata_nxt = req_wdata[w_winner*DATA_WIDTH +: DATA_WIDTH];
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_lat_cnt_nxt = c_LAT;
                w_state_nxt   = c_WAIT;
            end
            c_WAIT: begin
                w_lat_cnt_nxt = r_lat_cnt - CNT_W'(1);
                if (r_lat_cnt == CNT_W'(1)) begin
                    w_rdata_nxt = r_we ? '0 : mem_rdata;
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                w_ptr_nxt   = (r_owner == c_LAST) ? '0 : r_owner + PTR_W'(1);
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lat_cnt <= '0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    // The grant path is combinational from req_valid, so it is gated by rst
    // explicitly to stay quiet while reset is held.
    assign req_ready = (rst && (r_state == c_IDLE)) ? w_grant : '0;
    assign rsp_valid = (r_state == c_RESP) ? (NUM_REQ'(1) << r_owner) : '0;
    assign rsp_rdata = r_rdata;
    assign busy      = (r_state != c_IDLE);
    assign mem_en    = (r_state == c_ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_rr_arbiter.sv
// ============================================================================
//  Module  : tb_dmem_rr_arbiter
//  Brief   : Directed self-checking bench for dmem_rr_arbiter (L=1 and L=3).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_we    = '0;
    logic [63:0]  req_addr  = '0;
    logic [255:0] req_wdata = '0;
    logic [63:0]  mem_rdata    = '0;
    logic [63:0]  mem_rdata_l3 = '0;

    logic [3:0]   req_ready,    req_ready_l3;
    logic [3:0]   rsp_valid,    rsp_valid_l3;
    logic [63:0]  rsp_rdata,    rsp_rdata_l3;
    logic         busy,         busy_l3;
    logic         mem_en,       mem_en_l3;
    logic         mem_we,       mem_we_l3;
    logic [15:0]  mem_addr,     mem_addr_l3;
    logic [63:0]  mem_wdata,    mem_wdata_l3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_rr_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_WIDTH(64), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_rr_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_WIDTH(64), .MEM_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_l3),
        .rsp_valid(rsp_valid_l3), .rsp_rdata(rsp_rdata_l3), .busy(busy_l3),
        .mem_en(mem_en_l3), .mem_we(mem_we_l3), .mem_addr(mem_addr_l3),
        .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata_l3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        step();
        rst = 1'b0;
        req_valid = '0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, mem_en, mem_we, rsp_valid, req_ready} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {busy, mem_en, mem_we, rsp_valid, req_ready});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 144'b0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h wdata %h rdata %h expected 0", mem_addr, mem_wdata, rsp_rdata);
        end
        step();
        look();
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready_held: got %b expected 0000", req_ready);
        end
        step();
        rst = 1'b1;
        req_valid = '0;
        look();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
        step();
    endtask

    task automatic test_read();
        req_addr[15:0] = 16'h0010;
        req_we = '0;
        req_valid = 4'b0001;
        mem_rdata = 64'hDEADBEEF00000001;
        look();
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL read_ready: got %b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        look();
        n_tests++;
        if ({mem_en, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
            n_fail++;
            $display("FAIL read_issue: got en %b we %b addr %h busy %b expected 1 0 0010 1",
                     mem_en, mem_we, mem_addr, busy);
        end
        step();
        look();
        n_tests++;
        if ({mem_en, rsp_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL read_wait: got en %b rsp %b expected 0 0000", mem_en, rsp_valid);
        end
        step();
        look();
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 64'hDEADBEEF00000001) begin
            n_fail++;
            $display("FAIL read_resp: got rsp %b rdata %h expected 0001 deadbeef00000001", rsp_valid, rsp_rdata);
        end
        step();
        look();
        n_tests++;
        if ({busy, rsp_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL read_done: got busy %b rsp %b expected 0 0000", busy, rsp_valid);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        pulse_reset();
        req_addr  = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
        req_we    = '0;
        req_valid = 4'hF;
        for (int c = 0; c < 20; c++) begin
            look();
            exp_ready = (c % 4 == 0) ? (4'(1) << ((c / 4) % 4)) : 4'b0000;
            exp_rsp   = (c % 4 == 3) ? (4'(1) << ((c / 4) % 4)) : 4'b0000;
            n_tests++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            n_tests++;
            if (rsp_valid !== exp_rsp) begin
                n_fail++;
                $display("FAIL rr_rsp c=%0d: got %b expected %b", c, rsp_valid, exp_rsp);
            end
            if (c % 4 == 1) begin
                n_tests++;
                if (mem_addr !== 16'(((c / 4) % 4) << 8)) begin
                    n_fail++;
                    $display("FAIL rr_addr c=%0d: got %h expected %h", c, mem_addr, 16'(((c / 4) % 4) << 8));
                end
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_write();
        req_valid = 4'b0100;
        req_we    = 4'b0100;
        req_addr[47:32]    = 16'h00FF;
        req_wdata[191:128] = 64'h1234;
        look();
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL write_ready: got %b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        req_we    = '0;
        req_wdata[191:128] = 64'hFFFF;
        look();
        n_tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h00FF, 64'h1234}) begin
            n_fail++;
            $display("FAIL write_issue: got en %b we %b addr %h wdata %h expected 1 1 00ff 1234",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        look();
        n_tests++;
        if ({mem_en, mem_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL write_strobe_once: got en %b we %b expected 0 0", mem_en, mem_we);
        end
        step();
        look();
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL write_resp: got rsp %b rdata %h expected 0100 0", rsp_valid, rsp_rdata);
        end
        step();
    endtask

    task automatic test_pair();
        logic [3:0] exp_ready;
        pulse_reset();
        req_valid = 4'b1010;
        for (int c = 0; c < 16; c++) begin
            look();
            exp_ready = (c % 4 != 0) ? 4'b0000 : (((c / 4) % 2 == 0) ? 4'b0010 : 4'b1000);
            n_tests++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL pair_ready c=%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        // First transaction by requester 1 leaves ptr at 2.
        req_valid = 4'b0010;
        look();
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_first_ready: got %b expected 0010", req_ready);
        end
        step();
        req_valid = '0;
        repeat (3) step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        #1 rst = 1'b0;
        req_valid = 4'b0110;
        #1;
        n_tests++;
        if ({busy, mem_en, mem_we, rsp_valid, req_ready} !== 11'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got %b expected 0", {busy, mem_en, mem_we, rsp_valid, req_ready});
        end
        n_tests++;
        if ({mem_addr, rsp_rdata} !== 80'b0) begin
            n_fail++;
            $display("FAIL mid_reset_data: got addr %h rdata %h expected 0", mem_addr, rsp_rdata);
        end
        step();
        rst = 1'b1;
        // With ptr back at 0, requester 1 precedes 2; a stale ptr of 2 would pick 2.
        for (int c = 0; c < 8; c++) begin
            look();
            exp_ready = (c == 0) ? 4'b0010 : ((c == 4) ? 4'b0100 : 4'b0000);
            exp_rsp   = (c == 3) ? 4'b0010 : ((c == 7) ? 4'b0100 : 4'b0000);
            n_tests++;
            if (req_ready !== exp_ready || rsp_valid !== exp_rsp) begin
                n_fail++;
                $display("FAIL mid_after c=%0d: got ready %b rsp %b expected %b %b",
                         c, req_ready, rsp_valid, exp_ready, exp_rsp);
            end
            step();
            if (c == 0) req_valid[1] = 1'b0;
            if (c == 4) req_valid[2] = 1'b0;
        end
    endtask

    task automatic test_lat3();
        logic [4:0] exp_ctl;
        pulse_reset();
        req_addr[31:16] = 16'h0020;
        req_we    = '0;
        req_valid = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            mem_rdata_l3 = 64'h1000 + 64'(c);
            look();
            exp_ctl = {(c == 1), (c == 5) ? 4'b0010 : 4'b0000};
            n_tests++;
            if ({mem_en_l3, rsp_valid_l3} !== exp_ctl) begin
                n_fail++;
                $display("FAIL lat3_ctl c=%0d: got %b expected %b", c, {mem_en_l3, rsp_valid_l3}, exp_ctl);
            end
            if (c == 0) begin
                n_tests++;
                if (req_ready_l3 !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL lat3_ready: got %b expected 0010", req_ready_l3);
                end
            end
            if (c == 5) begin
                n_tests++;
                if (rsp_rdata_l3 !== 64'h1004) begin
                    n_fail++;
                    $display("FAIL lat3_rdata: got %h expected 1004", rsp_rdata_l3);
                end
            end
            step();
            if (c == 0) req_valid = '0;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_write();
        test_pair();
        test_reset_mid();
        test_lat3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
